mul_arbiter: RTL and testbench



---
 rtl/mul_arbiter_if.sv | 23 ++
 rtl/mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_mul_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Request/response bundle between the FOC transform blocks and the shared multiplier.
interface mul_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned D_WIDTH = 16
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*D_WIDTH-1:0] req_a;
  logic [N_REQ*D_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         rsp_valid;
  logic [D_WIDTH-1:0]       rsp_data;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin shared Q-format multiplier: one product per cycle, rounded and saturated.
// Optional sticky saturation flag with sat_clr/sat_flag ports under MUL_ARB_SAT_FLAG_EN.
module mul_arbiter #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned Q_BITS  = 15,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rstb,
  mul_arbiter_if.slave  bus
`ifdef MUL_ARB_SAT_FLAG_EN
  ,
  input  logic          sat_clr,
  output logic          sat_flag
`endif
);

  localparam int unsigned P_W   = 2 * D_WIDTH;
  localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic signed [P_W-1:0] RND   = P_W'(1) << (Q_BITS - 1);
  localparam logic signed [P_W-1:0] Q_MAX = {{(P_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [P_W-1:0] Q_MIN = {{(P_W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  logic [TAG_W-1:0]         rr_ptr;
  logic [TAG_W-1:0]         grant_idx;
  logic                     grant_vld;
  logic signed [D_WIDTH-1:0] a_sel;
  logic signed [D_WIDTH-1:0] b_sel;
  logic signed [P_W-1:0]    prod_c;
  logic [MUL_LAT-1:0]       vld_q;
  logic [TAG_W-1:0]         tag_q [MUL_LAT];
  logic                     fin_load;
  logic signed [P_W-1:0]    fin_prod;
  logic [D_WIDTH-1:0]       rsp_data_q;

  // Round half toward +inf, then drop the fractional bits.
  function automatic logic signed [P_W-1:0] scale(input logic signed [P_W-1:0] p);
    return (p + RND) >>> Q_BITS;
  endfunction

  function automatic logic [D_WIDTH-1:0] round_sat(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] q;
    q = scale(p);
    if (q > Q_MAX)      return Q_MAX[D_WIDTH-1:0];
    else if (q < Q_MIN) return Q_MIN[D_WIDTH-1:0];
    return q[D_WIDTH-1:0];
  endfunction

  // Round-robin search starting at rr_ptr; lowest offset wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % int'(N_REQ);
      if (bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = TAG_W'(idx);
      end
    end
  end

  assign bus.req_ready = grant_vld ? (N_REQ'(1) << grant_idx) : '0;

  assign a_sel  = bus.req_a[32'(grant_idx)*D_WIDTH +: D_WIDTH];
  assign b_sel  = bus.req_b[32'(grant_idx)*D_WIDTH +: D_WIDTH];
  assign prod_c = P_W'(a_sel) * P_W'(b_sel);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  // Valid/tag shift register; a bubble enters when nothing is granted.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_q <= '0;
      for (int j = 0; j < int'(MUL_LAT); j++) tag_q[j] <= '0;
    end else begin
      vld_q[0] <= grant_vld;
      tag_q[0] <= grant_idx;
      for (int j = 1; j < int'(MUL_LAT); j++) begin
        vld_q[j] <= vld_q[j-1];
        tag_q[j] <= tag_q[j-1];
      end
    end
  end

  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign fin_load = grant_vld;
      assign fin_prod = prod_c;
    end else begin : g_latn
      logic signed [P_W-1:0] prod_q [MUL_LAT-1];

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          for (int j = 0; j < int'(MUL_LAT) - 1; j++) prod_q[j] <= '0;
        end else begin
          prod_q[0] <= prod_c;
          for (int j = 1; j < int'(MUL_LAT) - 1; j++) prod_q[j] <= prod_q[j-1];
        end
      end

      assign fin_load = vld_q[MUL_LAT-2];
      assign fin_prod = prod_q[MUL_LAT-2];
    end
  endgenerate

  // Result register only updates on a valid entry so rsp_data holds between results.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rsp_data_q <= '0;
    end else if (fin_load) begin
      rsp_data_q <= round_sat(fin_prod);
    end
  end

  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = vld_q[MUL_LAT-1] ? (N_REQ'(1) << tag_q[MUL_LAT-1]) : '0;
  assign bus.busy      = |vld_q;

`ifdef MUL_ARB_SAT_FLAG_EN
  logic sat_flag_q;

  function automatic logic is_sat(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] q;
    q = scale(p);
    return (q > Q_MAX) || (q < Q_MIN);
  endfunction

  // Sticky; a saturating result landing in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sat_flag_q <= 1'b0;
    end else if (fin_load && is_sat(fin_prod)) begin
      sat_flag_q <= 1'b1;
    end else if (sat_clr) begin
      sat_flag_q <= 1'b0;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed plan steps plus randomized traffic
// against an arithmetic reference and an in-order response queue.
module tb_mul_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned QB  = 15;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rstb;
  logic sat_clr;
`ifdef MUL_ARB_SAT_FLAG_EN
  logic sat_flag;
`endif

  always #5 clk = ~clk;

  mul_arbiter_if #(.N_REQ(N), .D_WIDTH(DW)) bus ();

  mul_arbiter #(.D_WIDTH(DW), .Q_BITS(QB), .N_REQ(N), .MUL_LAT(LAT)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .bus      (bus)
`ifdef MUL_ARB_SAT_FLAG_EN
    ,
    .sat_clr  (sat_clr),
    .sat_flag (sat_flag)
`endif
  );

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    logic          sat;
    int            due;
  } ent_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            ptr    = 0;
  int            last_g = -1;
  ent_t          q [$];
  logic [DW-1:0] last_data;
  logic          sat_m;
  logic [DW-1:0] oa [N];
  logic [DW-1:0] ob [N];
  logic          pending [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product, +half LSB, floor shift, clamp.
  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            output logic sat);
    longint p, hi, lo;
    hi  = (longint'(1) <<< (DW - 1)) - 1;
    lo  = -hi - 1;
    p   = longint'($signed(a)) * longint'($signed(b));
    p   = (p + (longint'(1) <<< (QB - 1))) >>> QB;
    sat = (p > hi) || (p < lo);
    if (p > hi)      p = hi;
    else if (p < lo) p = lo;
    return p[DW-1:0];
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < int'(N); k++) begin
      if (v[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < int'(N); i++) begin
      bus.req_a[i*DW +: DW] = oa[i];
      bus.req_b[i*DW +: DW] = ob[i];
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    int            g;
    logic [N-1:0]  er;
    logic [N-1:0]  ev;
    logic          delivered;
    ent_t          e;
    #1;
    g  = exp_grant(bus.req_valid);
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    ev        = '0;
    delivered = 1'b0;
    if (q.size() != 0 && q[0].due == cyc) begin
      ev[q[0].tag] = 1'b1;
      last_data    = q[0].data;
      delivered    = 1'b1;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    chk("rsp_data", 64'(bus.rsp_data), 64'(last_data));
    chk("busy", 64'(bus.busy), 64'(q.size() != 0));
`ifdef MUL_ARB_SAT_FLAG_EN
    chk("sat_flag", 64'(sat_flag), 64'(sat_m));
`endif
    if (delivered) void'(q.pop_front());
    last_g = (rstb) ? g : -1;
    @(posedge clk);
    cyc++;
    if (rstb && g >= 0) begin
      e.tag  = g;
      e.data = ref_mul(oa[g], ob[g], e.sat);
      e.due  = cyc + int'(LAT) - 1;
      q.push_back(e);
      ptr = (g + 1) % int'(N);
    end
    if (rstb) begin
      if (q.size() != 0 && q[0].due == cyc && q[0].sat) sat_m = 1'b1;
      else if (sat_clr)                                 sat_m = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive('0);
    rstb = 1'b0;
    q.delete();
    ptr       = 0;
    last_data = '0;
    sat_m     = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    cycle();
    rstb = 1'b1;
  endtask

  task automatic drain(input int n);
    drive('0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic single(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] expv, input string tag);
    oa[idx] = a;
    ob[idx] = b;
    drive(N'(1) << idx);
    cycle();
    drain(int'(LAT) + 1);
    chk(tag, 64'(bus.rsp_data), 64'(expv));
  endtask

  initial begin
    rstb    = 1'b0;
    sat_clr = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      oa[i] = '0; ob[i] = '0; pending[i] = 1'b0;
    end
    drive('0);
    @(negedge clk);
    do_reset();

    // Q15 product 0.5*0.5
    single(0, 16'h4000, 16'h4000, 16'h2000, "q15_half");

    // All four requesting from reset: grants 0,1,2,3 back to back
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      oa[i] = DW'(16'h1000 * (i + 1));
      ob[i] = DW'(16'h7000 - 16'h1800 * i);
    end
    drive('1);
    for (int i = 0; i < int'(N); i++) begin
      cycle();
      chk("rr_order", 64'(last_g), 64'(i));
    end
    drain(int'(LAT) + 1);

    // Two continuous requesters alternate
    oa[0] = 16'h2345; ob[0] = 16'hC001;
    oa[2] = 16'h8001; ob[2] = 16'h3FFF;
    drive(4'b0101);
    for (int i = 0; i < 8; i++) cycle();
    drain(int'(LAT) + 1);

    // Saturation -1 * -1
    single(1, 16'h8000, 16'h8000, 16'h7FFF, "sat_neg1sq");
`ifdef MUL_ARB_SAT_FLAG_EN
    chk("sat_flag_set", 64'(sat_flag), 64'(1));
    sat_clr = 1'b1;
    cycle();
    sat_clr = 1'b0;
    cycle();
    chk("sat_flag_clr", 64'(sat_flag), 64'(0));
`endif

    // Rounding boundaries
    single(2, 16'h0001, 16'h4000, 16'h0001, "rnd_up");
    single(2, 16'hFFFF, 16'h4000, 16'h0000, "rnd_neg_half");
    single(3, 16'h7FFF, 16'h7FFF, 16'h7FFE, "rnd_max");

    // Reset mid-flight after accepting req3
    oa[3] = 16'h1234; ob[3] = 16'h5678;
    drive(4'b1000);
    cycle();
    do_reset();
    drain(int'(LAT) + 1);
    chk("mid_rst_data", 64'(bus.rsp_data), 64'(0));
    oa[0] = 16'h0100; ob[0] = 16'h0200;
    oa[2] = 16'h0300; ob[2] = 16'h0400;
    drive(4'b0101);
    cycle();
    chk("post_rst_grant", 64'(last_g), 64'(0));
    drain(int'(LAT) + 1);

    // Reset after accepting req1: pointer must not resume at 2
    oa[1] = 16'h4000; ob[1] = 16'h4000;
    drive(4'b0010);
    cycle();
    do_reset();
    drive(4'b0101);
    cycle();
    chk("post_rst_grant2", 64'(last_g), 64'(0));
    drain(int'(LAT) + 1);

    // Randomized traffic with held requests and occasional withdrawal
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] v;
      for (int i = 0; i < int'(N); i++) begin
        if (!pending[i] && ($urandom % 3) == 0) begin
          pending[i] = 1'b1;
          case ($urandom % 6)
            0:       oa[i] = 16'h8000;
            1:       oa[i] = 16'h7FFF;
            default: oa[i] = DW'($urandom);
          endcase
          case ($urandom % 6)
            0:       ob[i] = 16'h8000;
            1:       ob[i] = 16'hFFFF;
            default: ob[i] = DW'($urandom);
          endcase
        end else if (pending[i] && ($urandom % 16) == 0) begin
          pending[i] = 1'b0;
        end
      end
      v = '0;
      for (int i = 0; i < int'(N); i++) v[i] = pending[i];
      sat_clr = (($urandom % 8) == 0);
      drive(v);
      cycle();
      if (last_g >= 0) pending[last_g] = 1'b0;
    end
    sat_clr = 1'b0;
    drain(int'(LAT) + 2);
    chk("final_idle", 64'(bus.busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
